// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the Common Data Bus between completing FUs.
// Each FU owns a one-entry result buffer; one buffered result is broadcast per cycle.
module cdb_arbiter #(
  parameter int unsigned N_REQ = 5,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned REG_W = 5,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*TAG_W-1:0]   req_tag,
  input  logic [N_REQ*REG_W-1:0]   req_reg,
  input  logic [N_REQ*XLEN-1:0]    req_value,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [REG_W-1:0]         cdb_reg,
  output logic [XLEN-1:0]          cdb_value,
  output logic [N_REQ-1:0]         cdb_src,
  output logic [N_REQ-1:0]         pending
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]            buf_valid_q, buf_valid_d;
  logic [N_REQ-1:0][TAG_W-1:0] buf_tag_q,   buf_tag_d;
  logic [N_REQ-1:0][REG_W-1:0] buf_reg_q,   buf_reg_d;
  logic [N_REQ-1:0][XLEN-1:0]  buf_value_q, buf_value_d;
  logic [PTR_W-1:0]            rr_ptr_q,    rr_ptr_d;

  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q,   cdb_tag_d;
  logic [REG_W-1:0] cdb_reg_q,   cdb_reg_d;
  logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
  logic [N_REQ-1:0] cdb_src_q,   cdb_src_d;

  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_found;

  // Rotating priority: scan from rr_ptr upward, wrapping at N_REQ.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      int unsigned idx;
      idx = 32'(rr_ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && buf_valid_q[PTR_W'(idx)]) begin
        gnt_found              = 1'b1;
        gnt[PTR_W'(idx)]       = 1'b1;
        gnt_idx                = PTR_W'(idx);
      end
    end
  end

  // Ready depends only on registered state and flush, never on req_valid.
  always_comb begin
    req_ready = flush ? '0 : (~buf_valid_q | gnt);
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_reg_d   = buf_reg_q;
    buf_value_d = buf_value_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_src_d   = '0;
    cdb_tag_d   = cdb_tag_q;
    cdb_reg_d   = cdb_reg_q;
    cdb_value_d = cdb_value_q;

    if (flush) begin
      buf_valid_d = '0;
    end else begin
      // A capture on a draining entry overwrites it; the old contents still broadcast.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          buf_valid_d[i] = 1'b1;
          buf_tag_d[i]   = req_tag[i*TAG_W +: TAG_W];
          buf_reg_d[i]   = req_reg[i*REG_W +: REG_W];
          buf_value_d[i] = req_value[i*XLEN +: XLEN];
        end else if (gnt[i]) begin
          buf_valid_d[i] = 1'b0;
        end
      end

      if (gnt_found) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = buf_tag_q[gnt_idx];
        cdb_reg_d   = buf_reg_q[gnt_idx];
        cdb_value_d = buf_value_q[gnt_idx];
        cdb_src_d   = gnt;
        rr_ptr_d    = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_q <= '0;
      buf_tag_q   <= '0;
      buf_reg_q   <= '0;
      buf_value_q <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_reg_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_reg_q   <= buf_reg_d;
      buf_value_q <= buf_value_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_reg_q   <= cdb_reg_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_reg   = cdb_reg_q;
  assign cdb_value = cdb_value_q;
  assign cdb_src   = cdb_src_q;
  assign pending   = buf_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and scoreboarded checks of the CDB arbiter: latency, rotation order,
// same-cycle drain/capture, flush, asynchronous reset and random traffic.
module tb_cdb_arbiter;

  localparam int N  = 5;
  localparam int TW = 5;
  localparam int RW = 5;
  localparam int XW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*RW-1:0] req_reg;
  logic [N*XW-1:0] req_value;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [RW-1:0]   cdb_reg;
  logic [XW-1:0]   cdb_value;
  logic [N-1:0]    cdb_src;
  logic [N-1:0]    pending;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          src;
    logic [41:0] data;
    int          acc_e;
  } sb_t;
  sb_t sb[$];

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .REG_W(RW), .XLEN(XW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .req_reg   (req_reg),
    .req_value (req_value),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_reg   (cdb_reg),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] t, input logic [RW-1:0] r,
                         input logic [XW-1:0] v);
    req_valid[i]          = 1'b1;
    req_tag[i*TW +: TW]   = t;
    req_reg[i*RW +: RW]   = r;
    req_value[i*XW +: XW] = v;
  endtask

  task automatic chk_cdb(input string tag, input logic [TW-1:0] t, input logic [N-1:0] src);
    chk({tag, "_v"},   64'(cdb_valid), 64'(1));
    chk({tag, "_tag"}, 64'(cdb_tag),   64'(t));
    chk({tag, "_src"}, 64'(cdb_src),   64'(src));
  endtask

  initial begin
    logic [TW-1:0] a_t, b_t;
    logic          acc1, acc4;
    logic [TW-1:0] exp3_tag [7];
    int            edge_n;

    reset     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_reg   = '0;
    req_value = '0;

    // Reset state
    #12;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    chk("rst_cdb_src",   64'(cdb_src),   64'(0));
    chk("rst_cdb_data",  64'({cdb_tag, cdb_reg, cdb_value}), 64'(0));
    chk("rst_pending",   64'(pending),   64'(0));
    chk("rst_ready",     64'(req_ready), 64'(5'b11111));
    reset = 1'b1;
    tick();

    // Single Int result: two-edge latency, one-cycle broadcast
    set_req(0, 5'd3, 5'd7, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_ready0", 64'(req_ready[0]), 64'(1));
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_e0_cdbv", 64'(cdb_valid), 64'(0));
    chk("t1_e0_pend", 64'(pending),   64'(5'b00001));
    tick();
    @(negedge clk);
    chk_cdb("t1_e1", 5'd3, 5'b00001);
    chk("t1_e1_reg",   64'(cdb_reg),   64'(7));
    chk("t1_e1_value", 64'(cdb_value), 64'(32'hDEADBEEF));
    tick();
    @(negedge clk);
    chk("t1_e2_cdbv", 64'(cdb_valid), 64'(0));
    chk("t1_e2_src",  64'(cdb_src),   64'(0));
    chk("t1_e2_hold", 64'(cdb_tag),   64'(3));
    chk("t1_e2_pend", 64'(pending),   64'(0));

    // Reset pulse to bring rr_ptr back to 0
    tick();
    reset = 1'b0;
    #2;
    reset = 1'b1;

    // All five FUs at once, rotation from index 0
    for (int i = 0; i < N; i++) set_req(i, TW'(i + 1), RW'(i + 11), 32'h100 + 32'(i + 1));
    @(negedge clk);
    chk("t2_ready_all", 64'(req_ready), 64'(5'b11111));
    tick();
    req_valid = '0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("t2_ready", 64'(req_ready), 64'((1 << (k + 1)) - 1));
      if (k == 0) chk("t2_e0_cdbv", 64'(cdb_valid), 64'(0));
      else        chk_cdb("t2", TW'(k), N'(1 << (k - 1)));
      tick();
    end
    @(negedge clk);
    chk_cdb("t2_last", 5'd5, 5'b10000);
    chk("t2_last_reg",   64'(cdb_reg),   64'(15));
    chk("t2_last_value", 64'(cdb_value), 64'(32'h105));
    tick();
    @(negedge clk);
    chk("t2_idle_cdbv", 64'(cdb_valid), 64'(0));
    chk("t2_idle_pend", 64'(pending),   64'(0));

    // Move rr_ptr to 2 with a lone Mult0 result
    tick();
    set_req(1, 5'd9, 5'd9, 32'h9);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk_cdb("t3_pre", 5'd9, 5'b00010);
    tick();

    // Mult0 and LSU streaming: alternate grants, capture in grant cycle
    exp3_tag = '{5'd17, 5'd1, 5'd18, 5'd2, 5'd19, 5'd3, 5'd20};
    a_t = 5'd1;
    b_t = 5'd17;
    for (int s = 0; s <= 9; s++) begin
      if (s <= 5) begin
        set_req(1, a_t, a_t, 32'hA000_0000 | 32'(a_t));
        set_req(4, b_t, b_t, 32'hB000_0000 | 32'(b_t));
      end
      @(negedge clk);
      if (s >= 2 && s <= 8)
        chk_cdb("t3", exp3_tag[s-2], ((s - 1) % 2 == 1) ? 5'b10000 : 5'b00010);
      if (s <= 5) begin
        if (s == 0)          chk("t3_ready", 64'(req_ready & 5'b10010), 64'(5'b10010));
        else if (s % 2 == 1) chk("t3_ready", 64'(req_ready & 5'b10010), 64'(5'b10000));
        else                 chk("t3_ready", 64'(req_ready & 5'b10010), 64'(5'b00010));
      end
      if (s == 9) begin
        chk("t3_end_cdbv", 64'(cdb_valid), 64'(0));
        chk("t3_end_pend", 64'(pending),   64'(0));
      end
      acc1 = req_ready[1];
      acc4 = req_ready[4];
      tick();
      if (s < 5) begin
        if (acc1) a_t = a_t + 5'd1;
        if (acc4) b_t = b_t + 5'd1;
      end else begin
        req_valid = '0;
      end
    end

    // Flush with three buffers occupied; rr_ptr moved to 3 beforehand
    set_req(2, 5'd10, 5'd10, 32'h10);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk_cdb("t4_pre", 5'd10, 5'b00100);
    tick();
    set_req(0, 5'd7, 5'd7, 32'h7);
    set_req(2, 5'd8, 5'd8, 32'h8);
    set_req(3, 5'd9, 5'd9, 32'h9);
    tick();
    req_valid = '0;
    flush = 1'b1;
    @(negedge clk);
    chk("t4_flush_ready", 64'(req_ready), 64'(0));
    chk("t4_flush_pend",  64'(pending),   64'(5'b01101));
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_post_cdbv",  64'(cdb_valid), 64'(0));
    chk("t4_post_src",   64'(cdb_src),   64'(0));
    chk("t4_post_pend",  64'(pending),   64'(0));
    chk("t4_post_ready", 64'(req_ready), 64'(5'b11111));
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("t4_no_stale", 64'(cdb_valid), 64'(0));
    end
    tick();
    set_req(1, 5'd11, 5'd11, 32'h11);
    set_req(4, 5'd12, 5'd12, 32'h12);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk_cdb("t4_rr_first", 5'd12, 5'b10000);
    tick();
    @(negedge clk);
    chk_cdb("t4_rr_second", 5'd11, 5'b00010);
    tick();

    // Asynchronous reset while the CDB is valid
    set_req(2, 5'd13, 5'd13, 32'h13);
    set_req(4, 5'd14, 5'd14, 32'h14);
    tick();
    req_valid = '0;
    tick();
    #2;
    chk("t5_pre_cdbv", 64'(cdb_valid), 64'(1));
    reset = 1'b0;
    #1;
    chk("t5_rst_cdbv", 64'(cdb_valid), 64'(0));
    chk("t5_rst_pend", 64'(pending),   64'(0));
    chk("t5_rst_src",  64'(cdb_src),   64'(0));
    chk("t5_rst_tag",  64'(cdb_tag),   64'(0));
    reset = 1'b1;
    set_req(1, 5'd15, 5'd15, 32'h15);
    set_req(3, 5'd0, 5'd0, 32'h0);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk_cdb("t5_first", 5'd15, 5'b00010);
    tick();
    @(negedge clk);
    chk_cdb("t5_zero", 5'd0, 5'b01000);
    chk("t5_zero_reg",   64'(cdb_reg),   64'(0));
    chk("t5_zero_value", 64'(cdb_value), 64'(0));
    tick();

    // Random traffic against a scoreboard
    edge_n = 0;
    for (int c = 0; c < 2008; c++) begin
      if (c < 2000) begin
        req_valid = N'($urandom_range(0, 31));
        for (int i = 0; i < N; i++) begin
          req_tag[i*TW +: TW]   = TW'($urandom);
          req_reg[i*RW +: RW]   = RW'($urandom);
          req_value[i*XW +: XW] = $urandom;
        end
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (cdb_valid) begin
        int hit;
        hit = -1;
        chk("rnd_onehot", 64'($onehot(cdb_src)), 64'(1));
        for (int j = 0; j < sb.size(); j++)
          if (hit < 0 && (N'(1 << sb[j].src) == cdb_src)) hit = j;
        if (hit < 0) begin
          chk("rnd_unexpected", 64'(cdb_src), 64'(0));
        end else begin
          chk("rnd_data", 64'({cdb_tag, cdb_reg, cdb_value}), 64'(sb[hit].data));
          chk("rnd_wait_le5", 64'((edge_n - sb[hit].acc_e) <= 5), 64'(1));
          sb.delete(hit);
        end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i])
          sb.push_back('{i, {req_tag[i*TW +: TW], req_reg[i*RW +: RW], req_value[i*XW +: XW]},
                         edge_n + 1});
      @(posedge clk);
      edge_n++;
      #1;
    end
    chk("rnd_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
